// File: rtl/impartire_secventiala.sv
`timescale 1ns/1ps
// Sequential signed restoring divider: one quotient bit per clock, truncating toward zero.
// Remainder takes the sign of the dividend. Divide-by-zero and -2^(WIDTH-1)/-1 are flagged.
module impartire_secventiala #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] dividend,
  input  logic signed [WIDTH-1:0] divisor,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quotient,
  output logic signed [WIDTH-1:0] remainder,
  output logic                    div_by_zero,
  output logic                    overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dz;
  logic             ov;

  // dq first holds |dividend|, then is shifted out while quotient bits shift in.
  // An unsigned WIDTH-bit field already holds 2^(WIDTH-1), so only the remainder
  // and divisor need the extra bit.
  logic [WIDTH-1:0] dq;
  logic [WIDTH:0]   pr;
  logic [WIDTH:0]   dvs;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  function automatic logic signed [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] m,
                                                         input logic s);
    return s ? $signed(WIDTH'(-m)) : $signed(m);
  endfunction

  always_comb begin
    shifted  = {pr[WIDTH-1:0], dq[WIDTH-1]};
    trial    = {1'b0, shifted} - {1'b0, dvs};
    trial_ok = ~trial[WIDTH+1];
  end

  // Datapath registers: no reset, they are always loaded on the accepting edge.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      dq  <= mag(dividend);
      dvs <= {1'b0, mag(divisor)};
      pr  <= '0;
    end else if (state == CALC) begin
      if (trial_ok) begin
        pr <= trial[WIDTH:0];
        dq <= {dq[WIDTH-2:0], 1'b1};
      end else begin
        pr <= shifted;
        dq <= {dq[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            dz     <= (divisor == '0);
            ov     <= (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
            cnt    <= CNT_W'(WIDTH);
            busy   <= 1'b1;
            state  <= (divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          // On divide-by-zero dq was never shifted, so it still holds |dividend|.
          quotient    <= dz ? '1 : apply_sign(dq, sign_q);
          remainder   <= dz ? apply_sign(dq, sign_r) : apply_sign(pr[WIDTH-1:0], sign_r);
          div_by_zero <= dz;
          overflow    <= ov;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_impartire_secventiala.sv
`timescale 1ns/1ps
// Self-checking bench for impartire_secventiala (WIDTH=4): directed cases, reset
// abort, exhaustive back-to-back sweep and random operations against an integer model.
module tb_impartire_secventiala;

  localparam int W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [W-1:0] dividend = '0;
  logic signed [W-1:0] divisor = '0;
  logic                busy;
  logic                done;
  logic signed [W-1:0] quotient;
  logic signed [W-1:0] remainder;
  logic                div_by_zero;
  logic                overflow;

  int nvec = 0;
  int nmis = 0;

  impartire_secventiala #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division (truncates toward zero), plus the two special cases.
  task automatic model(input int a, input int b, output int q, output int r,
                       output int dz, output int ov);
    dz = 0; ov = 0;
    if (b == 0) begin
      q = -1; r = a; dz = 1;
    end else if (a == -(1 << (W-1)) && b == -1) begin
      q = -(1 << (W-1)); r = 0; ov = 1;
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done && lat < 40);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    int q, r, dz, ov;
    model(a, b, q, r, dz, ov);
    chk({tag, "_q"}, $signed(quotient), q);
    chk({tag, "_r"}, $signed(remainder), r);
    chk({tag, "_dz"}, div_by_zero, dz);
    chk({tag, "_ov"}, overflow, ov);
    chk({tag, "_busy_in_done"}, busy, 0);
    if (dz == 0 && ov == 0)
      chk({tag, "_identity"}, $signed(quotient) * b + $signed(remainder), a);
  endtask

  task automatic do_op(input string tag, input int a, input int b);
    int lat;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    chk({tag, "_busy"}, busy, 1);
    wait_done(lat);
    chk({tag, "_lat"}, lat, (b == 0) ? 1 : W + 1);
    check_result(tag, a, b);
  endtask

  initial begin
    int lat, ndone, qq, rr;
    logic signed [W-1:0] ta, tb;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    chk("rst_ov", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("7div2", 7, 2);
    do_op("m7div2", -7, 2);
    do_op("7divm2", 7, -2);
    do_op("m8divm1", -8, -1);
    do_op("5div0", 5, 0);

    // start pulsed again while busy must be ignored
    dividend = 4'sd6; divisor = 4'sd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    dividend = 4'sd1; divisor = 4'sd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; qq = 0; rr = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) begin ndone++; qq = quotient; rr = remainder; end
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_q", qq, 2);
    chk("ign_r", rr, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_q", $signed(quotient), 2);
      chk("hold_r", $signed(remainder), 0);
    end

    // asynchronous reset in the third CALC cycle
    dividend = 4'sd7; divisor = 4'sd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_q", quotient, 0);
    chk("arst_r", remainder, 0);
    chk("arst_dz", div_by_zero, 0);
    chk("arst_ov", overflow, 0);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("arst_nodone", ndone, 0);
    do_op("7div3", 7, 3);

    // exhaustive sweep, start held high so each op is accepted in the previous done cycle
    dividend = '0; divisor = '0; start = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ta = W'(i >> 4);
      tb = W'(i);
      @(posedge clk); #1;
      chk("exh_busy", busy, 1);
      if (i < 255) begin
        dividend = W'((i + 1) >> 4);
        divisor  = W'(i + 1);
      end else begin
        start = 1'b0;
      end
      wait_done(lat);
      chk("exh_lat", lat, (tb == 0) ? 1 : W + 1);
      check_result("exh", ta, tb);
    end

    // random operations with random idle gaps
    for (int k = 0; k < 150; k++) begin
      ta = W'($urandom);
      tb = W'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_op("rnd", ta, tb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
